// File: rtl/bru_exe_pkg.sv
// Shared definitions for the branch-resolution unit: issue_fun bit map,
// width defaults, execute-register state and op-kind decode.
package bru_exe_pkg;

    localparam int DW_DEF    = 64;
    localparam int RNBIT_DEF = 2;
    localparam int RDW_DEF   = 5 + RNBIT_DEF;
    localparam int FUN_W     = 8;

    // One-hot issue_fun bit positions {jal,jalr,beq,bne,blt,bge,bltu,bgeu}
    localparam int F_JAL  = 7;
    localparam int F_JALR = 6;
    localparam int F_BEQ  = 5;
    localparam int F_BNE  = 4;
    localparam int F_BLT  = 3;
    localparam int F_BGE  = 2;
    localparam int F_BLTU = 1;
    localparam int F_BGEU = 0;

    typedef enum logic {
        EXE_EMPTY,
        EXE_FULL
    } exe_state_e;

    typedef enum logic [1:0] {
        K_BR,
        K_JAL,
        K_JALR
    } op_kind_e;

    function automatic logic fun_onehot(input logic [FUN_W-1:0] f);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < FUN_W; i++) cnt = cnt + {3'd0, f[i]};
        return cnt == 4'd1;
    endfunction

    // Anything that is not a clean one-hot jal/jalr resolves as a branch;
    // the comparator then reports it not-taken.
    function automatic op_kind_e fun_kind(input logic [FUN_W-1:0] f);
        if (fun_onehot(f) && f[F_JAL])       return K_JAL;
        else if (fun_onehot(f) && f[F_JALR]) return K_JALR;
        else                                 return K_BR;
    endfunction

endpackage

// File: rtl/bru_exe_if.sv
// Issue / resolve / writeback bundle of the branch-resolution unit.
interface bru_exe_if
    import bru_exe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int RNBIT = RNBIT_DEF
) ();

    logic                 issue_valid;
    logic                 issue_ready;
    logic [FUN_W-1:0]     issue_fun;
    logic                 issue_is_rvc;
    logic [DW-1:0]        issue_pc;
    logic [DW-1:0]        issue_imm;
    logic [DW-1:0]        issue_op1;
    logic [DW-1:0]        issue_op2;
    logic [5+RNBIT-1:0]   issue_rd;

    logic                 bru_res_valid;
    logic                 bru_takenBranch;
    logic                 jalr_valid;
    logic [DW-1:0]        jalr_pc;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [DW-1:0]        wb_res;
    logic [5+RNBIT-1:0]   wb_rd;

    // Unit side
    modport slave (
        input  issue_valid, issue_fun, issue_is_rvc, issue_pc, issue_imm,
               issue_op1, issue_op2, issue_rd, wb_ready,
        output issue_ready, bru_res_valid, bru_takenBranch, jalr_valid,
               jalr_pc, wb_valid, wb_res, wb_rd
    );

    // Issue queue / frontend / register-file side
    modport master (
        output issue_valid, issue_fun, issue_is_rvc, issue_pc, issue_imm,
               issue_op1, issue_op2, issue_rd, wb_ready,
        input  issue_ready, bru_res_valid, bru_takenBranch, jalr_valid,
               jalr_pc, wb_valid, wb_res, wb_rd
    );

endinterface

// File: rtl/bru_exe_cmp.sv
// Branch condition evaluator; illegal fun encodings report not-taken.
module bru_cmp
    import bru_exe_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0]    op1,
    input  logic [DW-1:0]    op2,
    input  logic [FUN_W-1:0] fun,
    output logic             taken
);

    logic eq, lt_s, lt_u;

    // Compare once, select by the one-hot condition bit
    always_comb begin
        eq    = (op1 == op2);
        lt_s  = ($signed(op1) < $signed(op2));
        lt_u  = (op1 < op2);
        taken = 1'b0;
        if (fun_onehot(fun))
            taken = |(fun[F_BEQ:F_BGEU] & {eq, ~eq, lt_s, ~lt_s, lt_u, ~lt_u});
    end

endmodule

// File: rtl/gen_dffrs.sv
// Enabled flop bank with synchronous active-high reset to zero.
module gen_dffrs #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable, clear on reset
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/bru_exe.sv
// Branch-resolution execute stage: one-entry execute register, resolves
// conditional branches in its first FULL cycle and jal/jalr on the link
// writeback handshake.
module bru_exe
    import bru_exe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int RNBIT = RNBIT_DEF
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      flush,
    bru_exe_if.slave  bus
);

    localparam int RDW = 5 + RNBIT;

    typedef struct packed {
        logic [FUN_W-1:0] fun;
        logic             is_rvc;
        logic [DW-1:0]    pc;
        logic [DW-1:0]    imm;
        logic [DW-1:0]    op1;
        logic [DW-1:0]    op2;
        logic [RDW-1:0]   rd;
    } op_t;

    exe_state_e    state_q, state_d;
    op_t           op_d, op_q;
    op_kind_e      kind;
    logic          full, kill, retire, accept, taken;
    logic [DW-1:0] tgt, link;

    // Capture the offered micro-op; held whenever nothing is accepted
    always_comb begin
        op_d = '{fun:    bus.issue_fun,
                 is_rvc: bus.issue_is_rvc,
                 pc:     bus.issue_pc,
                 imm:    bus.issue_imm,
                 op1:    bus.issue_op1,
                 op2:    bus.issue_op2,
                 rd:     bus.issue_rd};
    end

    gen_dffrs #(.W($bits(op_t))) u_op (
        .clk (CLK),
        .rst (RST),
        .en  (accept),
        .d   (op_d),
        .q   (op_q)
    );

    bru_cmp #(.DW(DW)) u_cmp (
        .op1   (op_q.op1),
        .op2   (op_q.op2),
        .fun   (op_q.fun),
        .taken (taken)
    );

    // Execute register occupancy
    always_ff @(posedge CLK) begin
        if (RST) state_q <= EXE_EMPTY;
        else     state_q <= state_d;
    end

    // Retire / accept decision, result pulses and link writeback
    always_comb begin
        full   = (state_q == EXE_FULL);
        kill   = flush | RST;
        kind   = fun_kind(op_q.fun);
        tgt    = op_q.op1 + op_q.imm;
        link   = op_q.pc + (op_q.is_rvc ? DW'(2) : DW'(4));
        // Branches never wait; links wait for the register file
        retire = full & ((kind == K_BR) | bus.wb_ready);

        bus.issue_ready     = ~RST & (~full | retire);
        accept              = bus.issue_valid & bus.issue_ready & ~flush;

        bus.bru_res_valid   = full & (kind == K_BR) & ~kill;
        bus.bru_takenBranch = full & (kind == K_BR) & taken;
        bus.jalr_valid      = full & (kind == K_JALR) & bus.wb_ready & ~kill;
        bus.jalr_pc         = '0;
        bus.wb_valid        = full & (kind != K_BR) & ~kill;
        bus.wb_res          = '0;
        bus.wb_rd           = '0;
        if (full && kind == K_JALR) bus.jalr_pc = {tgt[DW-1:1], 1'b0};
        if (full && kind != K_BR) begin
            bus.wb_res = link;
            bus.wb_rd  = op_q.rd;
        end

        state_d = state_q;
        if (flush)       state_d = EXE_EMPTY;
        else if (accept) state_d = EXE_FULL;
        else if (retire) state_d = EXE_EMPTY;
    end

    // Malformed fun encodings should never reach the unit
    a_fun_onehot : assert property (@(posedge CLK) disable iff (RST)
        accept |-> fun_onehot(bus.issue_fun));

endmodule
